// File: rtl/deser_pkg.sv
// Shared types and widths for the sample-to-word deserializer.
// Build option: DESER_TLAST_CHECK_EN enables the upstream tlast framing check.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        FLUSH
    } deser_state_t;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 192;
    localparam int LANES    = WORD_W / SAMPLE_W;

endpackage

// File: rtl/deserializer_sv_axis_word_reg.sv
// Output word register for the deserializer: load, hold under
// back-pressure, drain on handshake.
module axis_word_reg #(
    parameter int W = 192
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         m_tready,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata,
    output logic         m_tlast,
    output logic         free
);

    assign free = !m_tvalid || m_tready;

    // Load wins over drain so a word can replace the one leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= load_data;
            m_tlast  <= load_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer_sv.sv
// Packs 16-bit AXIS samples into 192-bit words framed in packets.
// Build option: DESER_TLAST_CHECK_EN checks s00_axis_tlast and flushes early packets.
module deserializer_sv
    import deser_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = SAMPLE_W,
    parameter int C_M00_AXIS_TDATA_WIDTH = WORD_W,
    parameter int PACKET_COUNT           = 512
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic                                framing_err
);

    localparam int SW = C_S00_AXIS_TDATA_WIDTH;
    localparam int MW = C_M00_AXIS_TDATA_WIDTH;
    localparam int LN = MW / SW;
    localparam int PW = MW - SW;
    localparam int CW = (PACKET_COUNT > 1) ? $clog2(PACKET_COUNT) : 1;

    deser_state_t    state;
    logic [3:0]      lane;
    logic [CW-1:0]   word_cnt;
    logic [PW-1:0]   pack_buf;

    logic            accept;
    logic            last_lane;
    logic            last_word;
    logic            free;
    logic            load;
    logic [MW-1:0]   load_data;
    logic            load_last;

    assign last_lane = (lane == 4'(LN - 1));
    assign last_word = (word_cnt == CW'(PACKET_COUNT - 1));

    assign s00_axis_tready = (state == PACK) && (!last_lane || free);
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign m00_axis_tstrb  = '1;

    // Select what enters the output register this cycle.
    always_comb begin
        load      = 1'b0;
        load_data = {s00_axis_tdata, pack_buf};
        load_last = last_word;
        if (accept && last_lane)
            load = 1'b1;
`ifdef DESER_TLAST_CHECK_EN
        if (accept && last_lane && s00_axis_tlast)
            load_last = 1'b1;
        if (state == FLUSH && free) begin
            load      = 1'b1;
            load_data = {{SW{1'b0}}, pack_buf};
            load_last = 1'b1;
        end
`endif
    end

    // Packing state, lane and word counters.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state    <= IDLE;
            lane     <= '0;
            word_cnt <= '0;
            pack_buf <= '0;
        end else begin
            unique case (state)
                IDLE: state <= PACK;
                PACK: begin
                    if (accept && last_lane) begin
                        lane     <= '0;
                        pack_buf <= '0;
                        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
`ifdef DESER_TLAST_CHECK_EN
                        if (s00_axis_tlast)
                            word_cnt <= '0;
`endif
                    end else if (accept) begin
                        for (int i = 0; i < LN - 1; i++)
                            if (lane == 4'(i))
                                pack_buf[i*SW +: SW] <= s00_axis_tdata;
                        lane <= lane + 4'd1;
`ifdef DESER_TLAST_CHECK_EN
                        if (s00_axis_tlast)
                            state <= FLUSH;
`endif
                    end
                end
`ifdef DESER_TLAST_CHECK_EN
                FLUSH: begin
                    if (free) begin
                        lane     <= '0;
                        word_cnt <= '0;
                        pack_buf <= '0;
                        state    <= PACK;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DESER_TLAST_CHECK_EN
    // Sticky flag for any tlast that disagrees with the packet boundary.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset)
            framing_err <= 1'b0;
        else if (state == PACK && accept)
            if (s00_axis_tlast != (last_lane && last_word))
                framing_err <= 1'b1;
    end
`else
    logic unused_tlast;
    assign unused_tlast = s00_axis_tlast;
    assign framing_err  = 1'b0;
`endif

    axis_word_reg #(
        .W(MW)
    ) u_out (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .m_tready  (m00_axis_tready),
        .m_tvalid  (m00_axis_tvalid),
        .m_tdata   (m00_axis_tdata),
        .m_tlast   (m00_axis_tlast),
        .free      (free)
    );

endmodule

// File: tb/tb_deserializer_sv.sv
// Scoreboard bench for deserializer_sv with a 4-word packet.
// Define DESER_TLAST_CHECK_EN to also exercise the framing check.
module tb_deserializer_sv;

    localparam int PC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_tvalid = 1'b0;
    logic [15:0]  s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic         m_tready = 1'b1;
    logic         m_tvalid;
    logic [191:0] m_tdata;
    logic [23:0]  m_tstrb;
    logic         m_tlast;
    logic         ferr;

    int tests = 0;
    int fails = 0;
    bit rand_rdy = 1'b0;

    logic [192:0] q[$];
    logic [191:0] mbuf = '0;
    int           mlane = 0;
    int           mwc = 0;

    always #5 clk = ~clk;

    deserializer_sv #(
        .C_S00_AXIS_TDATA_WIDTH(16),
        .C_M00_AXIS_TDATA_WIDTH(192),
        .PACKET_COUNT(PC)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .framing_err     (ferr)
    );

    task automatic check(input string name, input logic [191:0] act,
                         input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit exp_last();
        return (mlane == 11) && (mwc == PC - 1);
    endfunction

    function automatic void model_accept(input logic [15:0] d, input logic l);
        bit lst;
        mbuf[mlane*16 +: 16] = d;
        if (mlane == 11) begin
            lst = (mwc == PC - 1);
`ifdef DESER_TLAST_CHECK_EN
            if (l) lst = 1'b1;
`endif
            q.push_back({lst, mbuf});
            mwc   = lst ? 0 : mwc + 1;
            mlane = 0;
            mbuf  = '0;
        end else begin
            mlane++;
`ifdef DESER_TLAST_CHECK_EN
            if (l) begin
                q.push_back({1'b1, mbuf});
                mwc   = 0;
                mlane = 0;
                mbuf  = '0;
            end
`endif
        end
    endfunction

    task automatic send(input logic [15:0] d, input logic l, output int waits);
        int  n;
        logic hs;
        n = 0;
        hs = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (!hs) n++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        waits = n;
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: sample %h not accepted", d);
        end else begin
            model_accept(d, l);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", 192'(s_tready), 192'(0));
        check("rst_m_tvalid", 192'(m_tvalid), 192'(0));
        check("rst_m_tdata", m_tdata, 192'(0));
        check("rst_m_tlast", 192'(m_tlast), 192'(0));
        check("rst_ferr", 192'(ferr), 192'(0));
        q.delete();
        mbuf  = '0;
        mlane = 0;
        mwc   = 0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_tready", 192'(s_tready), 192'(0));
        @(negedge clk);
        check("pack_s_tready", 192'(s_tready), 192'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_tready = 1'b1;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue_empty", 192'(q.size()), 192'(0));
    endtask

    // Scoreboard monitor plus hold-stability check.
    logic [192:0] got;
    logic [192:0] want;
    logic         held = 1'b0;
    logic [192:0] held_w;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                tests++;
                if (!m_tvalid || {m_tlast, m_tdata} !== held_w) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b %h want %h",
                             m_tvalid, {m_tlast, m_tdata}, held_w);
                end
            end
            if (m_tvalid && m_tready) begin
                got = {m_tlast, m_tdata};
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %h want none", got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        fails++;
                        $display("FAIL word: got %h want %h", got, want);
                    end
                end
            end
            held   = m_tvalid && !m_tready;
            held_w = {m_tlast, m_tdata};
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int w;
        int stalls;
        logic [191:0] w1;
        logic [191:0] w2;
        logic [191:0] k1;

        do_reset();
        check("tstrb", 192'(m_tstrb), 192'(24'hFFFFFF));

        // 1: single word 0..11, latency and packing order
        for (int i = 0; i < 12; i++) begin
            send(16'(i), exp_last(), w);
            if (i == 10)
                check("t1_no_early_valid", 192'(m_tvalid), 192'(0));
        end
        k1 = 192'h000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000;
        check("t1_valid_latency", 192'(m_tvalid), 192'(1));
        check("t1_word", m_tdata, k1);
        check("t1_tlast", 192'(m_tlast), 192'(0));
        drain();

        // 2: full packet plus one more word, no stalls
        do_reset();
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            send(16'h0200 + 16'(i), exp_last(), w);
            stalls += w;
        end
        check("t2_no_stall", 192'(stalls), 192'(0));
        drain();

        // 3: downstream stall at lane 11 of the second word
        do_reset();
        m_tready = 1'b0;
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < 12; i++) w1[i*16 +: 16] = 16'h0300 + 16'(i);
        for (int i = 0; i < 12; i++) w2[i*16 +: 16] = 16'h030c + 16'(i);
        for (int i = 0; i < 23; i++) send(16'h0300 + 16'(i), exp_last(), w);
        s_tvalid = 1'b1;
        s_tdata  = 16'h0317;
        s_tlast  = exp_last();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_stall_tready", 192'(s_tready), 192'(0));
            check("t3_hold_word1", m_tdata, w1);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        @(negedge clk);
        check("t3_release_tready", 192'(s_tready), 192'(1));
        @(posedge clk);
        #1;
        model_accept(s_tdata, s_tlast);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("t3_word2_valid", 192'(m_tvalid), 192'(1));
        check("t3_word2", m_tdata, w2);
        drain();

        // 4: reset mid-word discards partial data
        for (int i = 0; i < 5; i++) send(16'h0400 + 16'(i), exp_last(), w);
        do_reset();
        check("t4_no_valid", 192'(m_tvalid), 192'(0));
        for (int i = 0; i < 12; i++) send(16'h0410 + 16'(i), exp_last(), w);
        drain();

`ifdef DESER_TLAST_CHECK_EN
        // 5: early upstream tlast flushes a zero-padded word
        do_reset();
        for (int i = 0; i <= 20; i++)
            send(16'h0500 + 16'(i), 1'(i == 20), w);
        repeat (2) @(posedge clk);
        #1;
        check("t5_framing_err", 192'(ferr), 192'(1));
        for (int i = 0; i < 48; i++)
            send(16'h0600 + 16'(i), exp_last(), w);
        drain();
`endif

        // 6: random throttling on both sides
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
            send(16'($urandom), exp_last(), w);
        end
        rand_rdy = 1'b0;
        drain();
        check("t6_ferr_clear", 192'(ferr), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
